clarvi_regfile_writeback: RTL and testbench



---
 rtl/clarvi_regfile_writeback.sv | 147 ++++++++++++++
 tb/tb_clarvi_regfile_writeback.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_regfile_writeback.sv
// Writeback serializer: one 64-bit result in, up to four 16-bit part writes out, lowest part first.
// Optional bypass outputs are built when CLARVI_WB_FORWARD_EN is defined.
module clarvi_regfile_writeback #(
   parameter int NUM_PARTS = 4,
   parameter int PART_W    = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [4:0]                    in_register,
   input  logic [NUM_PARTS*PART_W-1:0]   in_value,
   input  logic [NUM_PARTS-1:0]          in_mask,
   output logic [1:0]                    write_part,
   output logic [4:0]                    write_register,
   output logic [PART_W-1:0]             data_in,
   output logic                          write_enable,
   output logic                          wb_busy,
   output logic                          wb_done
`ifdef CLARVI_WB_FORWARD_EN
   ,
   input  logic [NUM_PARTS*PART_W-1:0]   fwd_old_value,
   output logic                          fwd_valid,
   output logic [4:0]                    fwd_register,
   output logic [NUM_PARTS*PART_W-1:0]   fwd_value
`endif
);

   localparam int VALUE_W = NUM_PARTS * PART_W;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t                 r_state;
   logic [4:0]             r_reg;
   logic [VALUE_W-1:0]     r_value;
   logic [NUM_PARTS-1:0]   r_pending;

   logic                   w_accept;
   logic                   w_real;
   logic                   w_last;
   logic [NUM_PARTS-1:0]   w_pend_low;
   logic [NUM_PARTS-1:0]   w_in_low;
   logic [NUM_PARTS-1:0]   w_in_rest;
   logic [1:0]             w_pend_part;
   logic [1:0]             w_in_part;

   function automatic logic [1:0] low_index(input logic [NUM_PARTS-1:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int k = NUM_PARTS - 1; k >= 0; k--) begin
         if (v[k]) idx = 2'(k);
      end
      return idx;
   endfunction

   assign w_pend_low  = r_pending & (~r_pending + NUM_PARTS'(1));
   assign w_last      = (r_pending != '0) && ((r_pending & (r_pending - NUM_PARTS'(1))) == '0);
   assign w_pend_part = low_index(r_pending);

   assign w_in_low    = in_mask & (~in_mask + NUM_PARTS'(1));
   assign w_in_rest   = in_mask & ~w_in_low;
   assign w_in_part   = low_index(in_mask);

   // x0 and empty masks complete without touching the register file
   assign w_real      = (in_mask != '0) && (in_register != 5'd0);

   assign in_ready    = (r_state == IDLE) || ((r_state == WRITE) && w_last);
   assign w_accept    = in_valid && in_ready;
   assign wb_busy     = (r_state == WRITE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_reg          <= '0;
         r_value        <= '0;
         r_pending      <= '0;
         write_enable   <= 1'b0;
         write_part     <= '0;
         write_register <= '0;
         data_in        <= '0;
         wb_done        <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         wb_done      <= 1'b0;
         if (w_accept) begin
            r_reg   <= in_register;
            r_value <= in_value;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_real) begin
                     // first part leaves straight from the input latch to save a cycle
                     write_enable   <= 1'b1;
                     write_part     <= w_in_part;
                     write_register <= in_register;
                     data_in        <= in_value[w_in_part*PART_W +: PART_W];
                     r_pending      <= w_in_rest;
                     if (w_in_rest == '0) wb_done <= 1'b1;
                     else                 r_state <= WRITE;
                  end else begin
                     wb_done <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (r_pending == '0) begin
                  // a no-write result queued behind the previous last part
                  wb_done <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  write_enable   <= 1'b1;
                  write_part     <= w_pend_part;
                  write_register <= r_reg;
                  data_in        <= r_value[w_pend_part*PART_W +: PART_W];
                  r_pending      <= r_pending & ~w_pend_low;
                  if (w_last) begin
                     wb_done <= 1'b1;
                     if (w_accept) r_pending <= w_real ? in_mask : '0;
                     else          r_state   <= IDLE;
                  end
               end
            end
         endcase
      end
   end

`ifdef CLARVI_WB_FORWARD_EN
   logic [VALUE_W-1:0] w_fwd_merge;
   logic [VALUE_W-1:0] r_fwd_value;

   for (genvar gi = 0; gi < NUM_PARTS; gi++) begin : g_merge
      assign w_fwd_merge[gi*PART_W +: PART_W] =
         in_mask[gi] ? in_value[gi*PART_W +: PART_W] : fwd_old_value[gi*PART_W +: PART_W];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_fwd_value <= '0;
      else if (w_accept) r_fwd_value <= w_fwd_merge;
   end

   assign fwd_valid    = wb_busy;
   assign fwd_register = r_reg;
   assign fwd_value    = r_fwd_value;
`endif

endmodule

// File: tb/tb_clarvi_regfile_writeback.sv
// Randomized scoreboard bench for clarvi_regfile_writeback: expected write/done events and
// their cycles are derived from the issued results; a monitor checks every DUT event.
module tb_clarvi_regfile_writeback;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_register;
   logic [63:0] in_value;
   logic [3:0]  in_mask;
   logic [1:0]  write_part;
   logic [4:0]  write_register;
   logic [15:0] data_in;
   logic        write_enable;
   logic        wb_busy;
   logic        wb_done;
`ifdef CLARVI_WB_FORWARD_EN
   logic [63:0] fwd_old_value = '0;
   logic        fwd_valid;
   logic [4:0]  fwd_register;
   logic [63:0] fwd_value;
`endif

   always #5 clock = ~clock;

   clarvi_regfile_writeback dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_register    (in_register),
      .in_value       (in_value),
      .in_mask        (in_mask),
      .write_part     (write_part),
      .write_register (write_register),
      .data_in        (data_in),
      .write_enable   (write_enable),
      .wb_busy        (wb_busy),
      .wb_done        (wb_done)
`ifdef CLARVI_WB_FORWARD_EN
      ,
      .fwd_old_value  (fwd_old_value),
      .fwd_valid      (fwd_valid),
      .fwd_register   (fwd_register),
      .fwd_value      (fwd_value)
`endif
   );

   typedef struct {
      int          cyc;
      logic [24:0] ev;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] exp_rf [32];
   logic [63:0] dut_rf [32];
   int          n_checks = 0;
   int          n_errors = 0;
   int          ncyc     = 0;
   int          last_cyc = -10;
   int          n_txn    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] mk_ev(input logic we, input logic done, input logic [1:0] part,
                                         input logic [4:0] r, input logic [15:0] d);
      return {we, done, part, r, d};
   endfunction

   // Reference: each written part takes one cycle, no earlier than one cycle after
   // acceptance and never before the previous result's last event.
   task automatic model_accept(input logic [4:0] r, input logic [63:0] v, input logic [3:0] m,
                               input int acc);
      int start;
      int top;
      int k;
      logic [15:0] d;
      start = (acc + 1 > last_cyc + 1) ? acc + 1 : last_cyc + 1;
      if (r != 5'd0 && m != 4'd0) begin
         top = 0;
         for (int p = 0; p < 4; p++) if (m[p]) top = p;
         k = 0;
         for (int p = 0; p < 4; p++) begin
            if (m[p]) begin
               d = v[p*16 +: 16];
               sb.push_back('{cyc: start + k, ev: mk_ev(1'b1, p == top, 2'(p), r, d)});
               exp_rf[r][p*16 +: 16] = d;
               k++;
            end
         end
         last_cyc = start + k - 1;
      end else begin
         sb.push_back('{cyc: start, ev: mk_ev(1'b0, 1'b1, 2'd0, 5'd0, 16'd0)});
         last_cyc = start;
      end
   endtask

   // Monitor: plays the register file and checks every presented event against the queue.
   logic [24:0] mon_act;
   exp_t        mon_e;
   always @(negedge clock) begin
      ncyc++;
      if (reset_n === 1'b1 && (write_enable === 1'b1 || wb_done === 1'b1)) begin
         if (write_enable === 1'b1) begin
            mon_act = mk_ev(1'b1, wb_done, write_part, write_register, data_in);
            dut_rf[write_register][write_part*16 +: 16] = data_in;
         end else begin
            mon_act = mk_ev(1'b0, wb_done, 2'd0, 5'd0, 16'd0);
         end
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got %h expected none", mon_act);
         end else begin
            mon_e = sb.pop_front();
            check("event", 64'(mon_act), 64'(mon_e.ev));
            check("event_cycle", 64'(ncyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic send(input logic [4:0] r, input logic [63:0] v, input logic [3:0] m);
      bit done;
      int acc;
      done = 0;
      @(negedge clock);
      in_valid    = 1'b1;
      in_register = r;
      in_value    = v;
      in_mask     = m;
      for (int t = 0; t < 20 && !done; t++) begin
         if (in_ready === 1'b1) begin
            @(posedge clock);
            acc = ncyc;
            model_accept(r, v, m, acc);
            n_txn++;
            $display("txn %0d: reg=x%0d mask=%b value=%h accepted at cycle %0d", n_txn, r, m, v, acc);
            #1;
            done = 1;
         end else begin
            @(negedge clock);
         end
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
      end
   endtask

   task automatic idle(input int n);
      in_valid    = 1'b0;
      in_register = 5'($urandom_range(0, 31));
      in_value    = {$urandom(), $urandom()};
      in_mask     = 4'($urandom_range(0, 15));
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clock);
      repeat (2) @(negedge clock);
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] v;
      logic [63:0] old12;
      logic [4:0]  r;
      for (int i = 0; i < 32; i++) begin
         exp_rf[i] = '0;
         dut_rf[i] = '0;
      end
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_register = '0;
      in_value    = '0;
      in_mask     = '0;

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_write_enable", 64'(write_enable), 64'd0);
      check("rst_wb_done", 64'(wb_done), 64'd0);
      check("rst_wb_busy", 64'(wb_busy), 64'd0);
      check("rst_outputs", 64'({write_part, write_register, data_in}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      reset_n = 1'b1;

      // full 4-part write
      send(5'd5, 64'h1111_2222_3333_4444, 4'b1111);
      idle(0);
      @(negedge clock);
      check("busy_during_write", 64'(wb_busy), 64'd1);
      drain();
      check("x5_readback", dut_rf[5], 64'h1111_2222_3333_4444);

      // sparse mask keeps unwritten parts
      send(5'd7, 64'h0123_4567_89AB_CDEF, 4'b1111);
      idle(0);
      drain();
      send(5'd7, 64'hAAAA_BBBB_CCCC_DDDD, 4'b1010);
      idle(0);
      drain();
      check("x7_readback", dut_rf[7], 64'hAAAA_4567_CCCC_CDEF);

      // back-to-back results with valid held high
      send(5'd3, {$urandom(), $urandom()}, 4'b0011);
      send(5'd4, {$urandom(), $urandom()}, 4'b0001);
      idle(0);
      drain();

      // x0 is never written
      send(5'd0, {$urandom(), $urandom()}, 4'b1111);
      idle(0);
      @(negedge clock);
      check("x0_done_pulse", 64'(wb_done), 64'd1);
      check("x0_no_write", 64'(write_enable), 64'd0);
      check("x0_ready_next", 64'(in_ready), 64'd1);
      drain();

      // reset during the second part of a 4-part write
      old12 = exp_rf[12];
      v = {$urandom(), $urandom()};
      send(5'd12, v, 4'b1111);
      idle(0);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_write_enable", 64'(write_enable), 64'd0);
      sb.delete();
      exp_rf[12] = {old12[63:16], v[15:0]};
      repeat (2) @(negedge clock);
      reset_n  = 1'b1;
      last_cyc = -10;
      @(negedge clock);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_busy", 64'(wb_busy), 64'd0);
      repeat (5) @(negedge clock);
      check("x12_after_reset", dut_rf[12], exp_rf[12]);

      // empty mask
      send(5'd9, {$urandom(), $urandom()}, 4'b0000);
      idle(0);
      drain();
      check("x9_unchanged", dut_rf[9], exp_rf[9]);

      // randomized traffic with random gaps (gap 0 = back-to-back)
      for (int n = 0; n < 150; n++) begin
         r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         send(r, {$urandom(), $urandom()}, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
      end
      idle(0);
      drain();
      for (int i = 0; i < 32; i++) check($sformatf("rf_x%0d", i), dut_rf[i], exp_rf[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
